// File: rtl/dense_weight_fetch_pkg.sv
// Shared CNN package: FSM state codes, weight FIFO geometry and pointer helper.
package dense_weight_fetch_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int FIFO_DEPTH = 3;
    localparam int PTR_W      = 2;
    localparam int CNT_W      = 2;

    // Depth is not a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/dense_weight_fetch_fifo.sv
// 3-entry weight FIFO; simultaneous push and pop keep occupancy and order.
module weight_fifo
    import dense_weight_fetch_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    output logic [W-1:0]     rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wp, rp;
    logic             push_ok, pop_ok;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rp];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wp] <= wdata;
                wp      <= ptr_inc(wp);
            end
            if (pop_ok) rp <= ptr_inc(rp);
            if (push_ok && !pop_ok)      count <= count + CNT_W'(1);
            else if (pop_ok && !push_ok) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/dense_weight_fetch.sv
// Burst reader for the dense weight memory: issues reads under FIFO credit and
// streams the returned weights on a valid/ready port.
module dense_weight_fetch
    import dense_weight_fetch_pkg::*;
#(
    parameter int numWeightDense    = 507,
    parameter int addressWidthDense = 10,
    parameter int dataWidthDense    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [addressWidthDense-1:0] base_addr,
    input  logic [addressWidthDense-1:0] length,
    output logic                         mem_en,
    output logic [addressWidthDense-1:0] mem_addr,
    input  logic [dataWidthDense-1:0]    mem_rdata,
    output logic [dataWidthDense-1:0]    w_data,
    output logic                         w_valid,
    input  logic                         w_ready,
    output logic                         busy,
    output logic                         done
);

    localparam int AW = addressWidthDense;
    localparam logic [AW-1:0] LAST_ADDR = AW'(numWeightDense - 1);

    logic [1:0]       state;
    logic             zl_q;
    logic [AW-1:0]    addr_q, rd_left, beats_left;
    logic             rd_vld;
    logic             issue, beat;
    logic             ffull, fempty;
    logic [CNT_W-1:0] fcount, occ;

    // Only one read can be in flight (data returns next cycle), so rd_vld is the outstanding count.
    assign occ      = fcount + CNT_W'(rd_vld);
    assign issue    = (state == S_FETCH) && !ffull && (occ < CNT_W'(FIFO_DEPTH));
    assign beat     = w_valid && w_ready;
    assign w_valid  = !fempty;
    assign mem_en   = issue;
    assign mem_addr = (state == S_FETCH) ? addr_q : '0;
    assign busy     = (state == S_FETCH) || (state == S_DRAIN);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            zl_q       <= 1'b0;
            addr_q     <= '0;
            rd_left    <= '0;
            beats_left <= '0;
            rd_vld     <= 1'b0;
        end else begin
            rd_vld <= issue;
            if (beat && state != S_IDLE) beats_left <= beats_left - AW'(1);
            case (state)
                S_IDLE: begin
                    // Zero-length request waits one cycle so done lands where first data would.
                    if (zl_q) begin
                        zl_q  <= 1'b0;
                        state <= S_DONE;
                    end else if (start) begin
                        if (length == '0) begin
                            zl_q <= 1'b1;
                        end else begin
                            state      <= S_FETCH;
                            addr_q     <= base_addr;
                            rd_left    <= length;
                            beats_left <= length;
                        end
                    end
                end
                S_FETCH: begin
                    if (issue) begin
                        addr_q  <= (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
                        rd_left <= rd_left - AW'(1);
                        if (rd_left == AW'(1)) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (beat && beats_left == AW'(1)) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    weight_fifo #(.W(dataWidthDense)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_vld),
        .wdata (mem_rdata),
        .pop   (beat),
        .rdata (w_data),
        .full  (ffull),
        .empty (fempty),
        .count (fcount)
    );

endmodule

// File: tb/tb_dense_weight_fetch.sv
// Self-checking bench: table of bursts against a memory model and data scoreboard.
module tb_dense_weight_fetch;

    localparam int NW = 507;
    localparam int AW = 10;
    localparam int DW = 8;

    typedef struct {
        int base;
        int len;
        int stall_lo;
        int stall_hi;
        int second;
        int exp_done;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          w_ready = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] length = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_en, w_valid, busy, done;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] w_data;

    logic [DW-1:0] mem_model [NW];
    logic [DW-1:0] sb [$];
    int n_checks = 0;
    int n_fail = 0;

    dense_weight_fetch #(
        .numWeightDense(NW), .addressWidthDense(AW), .dataWidthDense(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .length(length), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .w_data(w_data), .w_valid(w_valid),
        .w_ready(w_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_en) mem_rdata <= mem_model[mem_addr];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_burst(input vec_t v);
        int exp_addr = v.base;
        int done_cyc = -1;
        int n_done = 0, n_beats = 0, n_reads = 0, reads_pre = 0;
        bit first_xfer = 0, hold = 0;
        logic [DW-1:0] held = '0;
        @(negedge clk);
        start = 1'b1;
        base_addr = AW'(v.base);
        length = AW'(v.len);
        for (int i = 0; i < v.len; i++) sb.push_back(mem_model[(v.base + i) % NW]);
        for (int c = 0; c < 300; c++) begin
            if (c > 0) start = (c == v.second);
            w_ready = !(c >= v.stall_lo && c <= v.stall_hi);
            #1;
            if (hold) begin
                chk("hold_valid", int'(w_valid), 1);
                chk("hold_data", int'(w_data), int'(held));
            end
            if (mem_en) begin
                chk("mem_addr", int'(mem_addr), exp_addr);
                exp_addr = (exp_addr + 1) % NW;
                n_reads++;
                if (!first_xfer) reads_pre++;
            end
            if (w_valid && w_ready) begin
                n_beats++;
                first_xfer = 1;
                if (sb.size() == 0) chk("beat_extra", n_beats, 0);
                else chk("beat_data", int'(w_data), int'(sb.pop_front()));
            end
            hold = w_valid && !w_ready;
            held = w_data;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c == 1) chk("busy_c1", int'(busy), int'(v.len > 0));
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_cycle", done_cyc, v.exp_done);
        chk("done_count", n_done, 1);
        chk("beats", n_beats, v.len);
        chk("reads", n_reads, v.len);
        chk("reads_before_xfer_le3", int'(reads_pre <= 3), 1);
        chk("sb_empty", sb.size(), 0);
        sb.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_en"}, int'(mem_en), 0);
        chk({tag, "_mem_addr"}, int'(mem_addr), 0);
        chk({tag, "_w_valid"}, int'(w_valid), 0);
        chk({tag, "_w_data"}, int'(w_data), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{0,   4, 1000, 0, -1, 7};
        vecs[1] = '{505, 4, 1000, 0, -1, 7};
        vecs[2] = '{10,  5, 3,    8, -1, 14};
        vecs[3] = '{100, 0, 1000, 0, -1, 2};
        vecs[4] = '{300, 7, 1000, 0, -1, 10};
        vecs[5] = '{0,   4, 1000, 0, 3,  7};

        for (int i = 0; i < NW; i++) mem_model[i] = DW'(i * 37 + 5);
        mem_model[0] = 8'h11;
        mem_model[1] = 8'h22;
        mem_model[2] = 8'h33;
        mem_model[3] = 8'h44;

        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++) run_burst(vecs[k]);

        // Reset asserted in cycle 4 of a 10-weight burst.
        @(negedge clk);
        start = 1'b1;
        base_addr = '0;
        length = AW'(10);
        w_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 4) rst_n = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("post_reset_w_valid", int'(w_valid), 0);
            chk("post_reset_mem_en", int'(mem_en), 0);
        end
        run_burst('{0, 2, 1000, 0, -1, 5});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dense_weight_fetch.md
DENSE_WEIGHT_FETCH -- requirements
Module: dense_weight_fetch

Interface
REQ-001 SHALL have parameter numWeightDense, default 507, meaning the number of weight words in the dense weight memory.
REQ-002 SHALL have parameter addressWidthDense, default 10, meaning the memory address width.
REQ-003 SHALL have parameter dataWidthDense, default 8, meaning the weight word width.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on posedge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-007 SHALL have port base_addr  input  addressWidthDense  first weight address, sampled with start.
REQ-008 SHALL have port length  input  addressWidthDense  number of weights to fetch, sampled with start.
REQ-009 SHALL have port mem_en  output  1  read enable to the dense weight memory.
REQ-010 SHALL have port mem_addr  output  addressWidthDense  read address to the dense weight memory.
REQ-011 SHALL have port mem_rdata  input  dataWidthDense  memory read data, valid the cycle after mem_en.
REQ-012 SHALL have port w_data  output  dataWidthDense  streamed weight.
REQ-013 SHALL have port w_valid  output  1  w_data holds a weight.
REQ-014 SHALL have port w_ready  input  1  consumer accepts; a beat transfers when w_valid and w_ready are both high.
REQ-015 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the last beat of a burst transfers.

Function
REQ-017 SHALL implement states IDLE, FETCH, DRAIN, DONE.
- IDLE->FETCH on start with length>0.
- IDLE->DONE on start with length==0.
- FETCH->DRAIN when the length-th read has issued.
- DRAIN->DONE when the last beat transfers.
- DONE->IDLE unconditionally.
REQ-018 SHALL keep read latency fixed: start high in cycle 0 gives mem_en=1 with mem_addr=base_addr in cycle 1, mem_rdata captured at the end of cycle 2, and w_valid=1 in cycle 3.
REQ-019 SHALL buffer weights in a 3-entry FIFO and issue a read only when FIFO occupancy plus reads outstanding (issued but not yet written) is less than 3.
REQ-020 SHALL sustain one beat per cycle while w_ready is held high.
REQ-021 SHALL increment mem_addr by 1 per issued read and wrap from numWeightDense-1 to 0.
REQ-022 SHALL drive mem_addr and mem_en only in FETCH, with mem_en=0 in all other states.
REQ-023 SHALL present w_data from the FIFO head unmodified; any offset is applied by the memory.
REQ-024 SHALL keep w_data stable and w_valid high until the beat transfers.
REQ-025 SHALL ignore start while busy is high.
REQ-026 SHALL drop all weights on a length==0 burst, pulsing done in cycle 2 with no mem_en.
REQ-027 SHALL, when a beat pops and a capture writes the FIFO in the same cycle, keep occupancy unchanged with order preserved.
REQ-028 SHALL assert done only in the DONE state and busy in FETCH and DRAIN.

Reset
REQ-029 SHALL, on rst_n low at a clock edge, go to IDLE with FIFO emptied, outstanding count cleared, mem_en=0, mem_addr=0, w_valid=0, w_data=0, busy=0, done=0.
REQ-030 SHALL abort a burst mid-operation on reset without emitting further beats, and SHALL ignore any memory data returning after reset.

Structure
REQ-031 SHALL place the state enumeration and the FIFO depth constant (3) in the shared CNN package.
REQ-032 SHALL implement the FIFO as one sub-module, weight_fifo, with push, pop, full, empty and count.

Verification
REQ-033 SHALL cover this bench case: base=0, length=4, w_ready=1, memory words 0x11,0x22,0x33,0x44 -> w_valid in cycles 3-6 with data in order, done in cycle 7.
REQ-034 SHALL cover this bench case: base=505, length=4 -> mem_addr sequence 505,506,0,1.
REQ-035 SHALL cover this bench case: length=5, w_ready low in cycles 3-8 -> at most 3 reads issued before the first transfer, no beat lost or duplicated, 5 beats total.
REQ-036 SHALL cover this bench case: length=0 -> no mem_en and done in cycle 2.
REQ-037 SHALL cover this bench case: second start during a burst -> ignored, and a single done.
REQ-038 SHALL cover this bench case: rst_n low in cycle 4 of a length=10 burst -> next cycle all outputs at reset values, and a new start=1 with base=0 and length=2 completes normally.
